// File: rtl/archie_mem_arbiter.sv
// archie_mem_arbiter
//   Shares one SDRAM wishbone port between the core and the ROM download
//   path. A rising dl_active first zeroes ERASE_WORDS words from address 0,
//   then streams 16-bit download halfwords into the ROM window at ROM_BASE.
//
// Ports
//   clk_sys, reset            clock, synchronous active-high reset
//   dl_active/dl_wr/dl_addr/dl_data   download source (byte address, halfword data)
//   dl_wait                   stall to download source
//   dl_busy                   download sequence in progress (holds core in reset)
//   core_*                    core wishbone master side
//   ram_*                     SDRAM controller wishbone side
//
// state      | meaning
// S_IDLE     | no access; core bus passed through to SDRAM
// S_CORE     | core owns SDRAM until its cycle ends
// S_ERASE    | zeroing word erase_cnt
// S_DL_IDLE  | erase done, waiting for a download strobe
// S_DL_WRITE | writing the latched halfword
// S_DL_DRAIN | one idle cycle before handing SDRAM back to the core

module archie_mem_arbiter #(
  parameter int          ERASE_WORDS = 1048576,
  parameter logic [1:0]  ROM_BASE    = 2'b01
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [21:0] dl_addr,
  input  logic [15:0] dl_data,
  output logic        dl_wait,
  output logic        dl_busy,
  input  logic        core_stb,
  input  logic        core_cyc,
  input  logic        core_we,
  input  logic [3:0]  core_sel,
  input  logic [21:0] core_adr,
  input  logic [31:0] core_dat_w,
  output logic        core_ack,
  output logic        ram_stb,
  output logic        ram_cyc,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [23:0] ram_adr,
  output logic [31:0] ram_dat_w,
  input  logic        ram_ack
);

  localparam int CNT_W = (ERASE_WORDS > 1) ? $clog2(ERASE_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ERASE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORE,
    S_ERASE,
    S_DL_IDLE,
    S_DL_WRITE,
    S_DL_DRAIN
  } state_t;

  state_t           state, state_nxt;
  logic             dl_active_q;
  logic             pending, pending_nxt;
  logic [CNT_W-1:0] erase_cnt, erase_cnt_nxt;
  logic [21:1]      dl_addr_q, dl_addr_nxt;
  logic [15:0]      dl_data_q, dl_data_nxt;

  logic             stb_c, cyc_c, we_c, core_ack_c, wait_c, busy_c;
  logic [3:0]       sel_c;
  logic [23:0]      adr_c;
  logic [31:0]      dat_c;
  logic             dl_rise;
  logic             core_acked;

  // Byte lane within a halfword is irrelevant: writes are halfword-wide.
  logic unused_dl_addr_bit;
  assign unused_dl_addr_bit = dl_addr[0];

  assign dl_rise    = dl_active & ~dl_active_q;
  assign core_acked = ram_ack & core_stb;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= S_IDLE;
      dl_active_q <= 1'b0;
      pending     <= 1'b0;
      erase_cnt   <= '0;
      dl_addr_q   <= '0;
      dl_data_q   <= '0;
    end else begin
      state       <= state_nxt;
      dl_active_q <= dl_active;
      pending     <= pending_nxt;
      erase_cnt   <= erase_cnt_nxt;
      dl_addr_q   <= dl_addr_nxt;
      dl_data_q   <= dl_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    erase_cnt_nxt = erase_cnt;
    dl_addr_nxt   = dl_addr_q;
    dl_data_nxt   = dl_data_q;
    stb_c         = 1'b0;
    cyc_c         = 1'b0;
    we_c          = 1'b0;
    sel_c         = 4'b0000;
    adr_c         = 24'h000000;
    dat_c         = 32'h00000000;
    core_ack_c    = 1'b0;
    wait_c        = 1'b0;
    busy_c        = 1'b0;

    case (state)
      S_IDLE: begin
        stb_c      = core_stb;
        cyc_c      = core_cyc;
        we_c       = core_we;
        sel_c      = core_sel;
        adr_c      = {2'b00, core_adr};
        dat_c      = core_dat_w;
        core_ack_c = core_acked;
        // A core cycle already on the bus is granted first so its request
        // is not yanked away; the download then waits as pending.
        if (core_cyc) begin
          state_nxt   = S_CORE;
          pending_nxt = dl_rise;
        end else if (dl_rise) begin
          state_nxt     = S_ERASE;
          erase_cnt_nxt = '0;
        end
      end

      S_CORE: begin
        stb_c      = core_stb;
        cyc_c      = core_cyc;
        we_c       = core_we;
        sel_c      = core_sel;
        adr_c      = {2'b00, core_adr};
        dat_c      = core_dat_w;
        core_ack_c = core_acked;
        wait_c     = pending;
        if ((pending || dl_rise) && (core_acked || !core_cyc)) begin
          state_nxt     = S_ERASE;
          pending_nxt   = 1'b0;
          erase_cnt_nxt = '0;
        end else if (dl_rise) begin
          pending_nxt = 1'b1;
        end else if (!core_cyc) begin
          state_nxt = S_IDLE;
        end
      end

      S_ERASE: begin
        stb_c  = 1'b1;
        cyc_c  = 1'b1;
        we_c   = 1'b1;
        sel_c  = 4'b1111;
        adr_c  = 24'(erase_cnt);
        wait_c = 1'b1;
        busy_c = 1'b1;
        if (ram_ack) begin
          if (!dl_active) begin
            state_nxt = S_DL_DRAIN;
          end else if (erase_cnt == CNT_LAST) begin
            state_nxt = S_DL_IDLE;
          end else begin
            erase_cnt_nxt = erase_cnt + 1'b1;
          end
        end
      end

      S_DL_IDLE: begin
        busy_c = 1'b1;
        // Stall asserts combinationally with the strobe so the source never
        // issues a second one before the write is accepted.
        wait_c = dl_wr;
        if (dl_wr) begin
          state_nxt   = S_DL_WRITE;
          dl_addr_nxt = dl_addr[21:1];
          dl_data_nxt = dl_data;
        end else if (!dl_active) begin
          state_nxt = S_DL_DRAIN;
        end
      end

      S_DL_WRITE: begin
        stb_c  = 1'b1;
        cyc_c  = 1'b1;
        we_c   = 1'b1;
        sel_c  = dl_addr_q[1] ? 4'b1100 : 4'b0011;
        adr_c  = {ROM_BASE, 2'b00, dl_addr_q[21:2]};
        dat_c  = {dl_data_q, dl_data_q};
        wait_c = 1'b1;
        busy_c = 1'b1;
        if (ram_ack) begin
          state_nxt = dl_active ? S_DL_IDLE : S_DL_DRAIN;
        end
      end

      S_DL_DRAIN: begin
        busy_c    = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are held at their idle values for as long as reset is high,
  // including the pass-through path.
  assign ram_stb   = reset ? 1'b0         : stb_c;
  assign ram_cyc   = reset ? 1'b0         : cyc_c;
  assign ram_we    = reset ? 1'b0         : we_c;
  assign ram_sel   = reset ? 4'b0000      : sel_c;
  assign ram_adr   = reset ? 24'h000000   : adr_c;
  assign ram_dat_w = reset ? 32'h00000000 : dat_c;
  assign core_ack  = reset ? 1'b0         : core_ack_c;
  assign dl_wait   = reset ? 1'b0         : wait_c;
  assign dl_busy   = reset ? 1'b0         : busy_c;

endmodule

// File: tb/tb_archie_mem_arbiter.sv
// Bench for archie_mem_arbiter: random-latency SDRAM responder logs every
// accepted access; expectations come from the arbiter's rules (erase list,
// ROM address arithmetic, core pass-through).

module tb_archie_mem_arbiter;

  localparam int EW = 8;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        dl_active = 1'b0;
  logic        dl_wr = 1'b0;
  logic [21:0] dl_addr = '0;
  logic [15:0] dl_data = '0;
  logic        dl_wait, dl_busy;
  logic        core_stb = 1'b0, core_cyc = 1'b0, core_we = 1'b0;
  logic [3:0]  core_sel = '0;
  logic [21:0] core_adr = '0;
  logic [31:0] core_dat_w = '0;
  logic        core_ack;
  logic        ram_stb, ram_cyc, ram_we;
  logic [3:0]  ram_sel;
  logic [23:0] ram_adr;
  logic [31:0] ram_dat_w;
  logic        ram_ack = 1'b0;

  archie_mem_arbiter #(.ERASE_WORDS(EW), .ROM_BASE(2'b01)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_wait(dl_wait), .dl_busy(dl_busy),
    .core_stb(core_stb), .core_cyc(core_cyc), .core_we(core_we),
    .core_sel(core_sel), .core_adr(core_adr), .core_dat_w(core_dat_w),
    .core_ack(core_ack),
    .ram_stb(ram_stb), .ram_cyc(ram_cyc), .ram_we(ram_we), .ram_sel(ram_sel),
    .ram_adr(ram_adr), .ram_dat_w(ram_dat_w), .ram_ack(ram_ack)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [23:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        we;
    logic        wt;
  } txn_t;

  txn_t txq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   min_lat = 1, max_lat = 3, lat = 1, wait_cnt = 0;
  bit   stray_ack = 1'b0;
  int   core_ack_cnt = 0;
  int   busy_ack_viol = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SDRAM responder: acks a held request after a random number of cycles.
  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      ram_ack = 1'b0;
      if (stray_ack) begin
        ram_ack = 1'b1;
      end else if (!reset && ram_stb && ram_cyc) begin
        if (wait_cnt >= lat) begin
          ram_ack = 1'b1;
          txq.push_back({ram_adr, ram_sel, ram_dat_w, ram_we, dl_wait});
          wait_cnt = 0;
          lat = int'($urandom_range(max_lat, min_lat));
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk_sys) begin
    if (core_ack) core_ack_cnt++;
    if (core_ack && dl_busy) busy_ack_viol++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic set_lat(input int mn, input int mx);
    min_lat = mn;
    max_lat = mx;
    lat = int'($urandom_range(mx, mn));
  endtask

  task automatic wait_txn(output txn_t t, output bit ok);
    t = '0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_sys);
      if (txq.size() > 0) begin
        t = txq.pop_front();
        ok = 1'b1;
      end
    end
  endtask

  task automatic expect_erase(input int n);
    txn_t t;
    bit   ok;
    for (int i = 0; i < n; i++) begin
      wait_txn(t, ok);
      check_val("erase_seen", 32'(ok), 1);
      check_val("erase_adr", 32'(t.adr), 32'(i));
      check_val("erase_sel", 32'(t.sel), 32'hF);
      check_val("erase_dat", t.dat, 0);
      check_val("erase_we", 32'(t.we), 1);
      check_val("erase_wait", 32'(t.wt), 1);
    end
  endtask

  task automatic core_access(input logic [21:0] adr, input logic we,
                             input logic [3:0] sel, input logic [31:0] dat);
    txn_t t;
    bit   ok, acked;
    int   a0;
    @(negedge clk_sys);
    a0 = core_ack_cnt;
    core_cyc = 1'b1; core_stb = 1'b1; core_we = we;
    core_sel = sel; core_adr = adr; core_dat_w = dat;
    #1 check_val("core_pass_stb", 32'(ram_stb), 1);
    acked = 1'b0;
    for (int i = 0; i < 50 && !acked; i++) begin
      @(negedge clk_sys);
      if (core_ack) acked = 1'b1;
    end
    check_val("core_ack_seen", 32'(acked), 1);
    @(posedge clk_sys);
    #2;
    core_cyc = 1'b0; core_stb = 1'b0; core_we = 1'b0;
    repeat (3) @(negedge clk_sys);
    #1;
    check_val("core_ack_once", 32'(core_ack_cnt - a0), 1);
    check_val("core_idle_stb", 32'(ram_stb), 0);
    wait_txn(t, ok);
    check_val("core_txn_seen", 32'(ok), 1);
    check_val("core_adr", 32'(t.adr), 32'(adr));
    check_val("core_we", 32'(t.we), 32'(we));
    check_val("core_sel", 32'(t.sel), 32'(sel));
    check_val("core_dat", t.dat, dat);
  endtask

  task automatic dl_write(input logic [21:0] a, input logic [15:0] d);
    txn_t        t;
    bit          ok, rdy;
    logic [31:0] exp_adr, exp_sel, exp_dat;
    rdy = 1'b0;
    for (int i = 0; i < 50 && !rdy; i++) begin
      @(negedge clk_sys);
      if (!dl_wait) rdy = 1'b1;
    end
    check_val("dl_ready", 32'(rdy), 1);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
    #1 check_val("dl_wait_same_cycle", 32'(dl_wait), 1);
    @(negedge clk_sys);
    dl_wr = 1'b0;
    wait_txn(t, ok);
    // ROM window starts at word (1 << 22); halfword index selects the lanes.
    exp_adr = (32'd1 << 22) + (32'(a) / 4);
    exp_sel = (((32'(a) / 2) % 2) == 1) ? 32'hC : 32'h3;
    exp_dat = 32'(d) * 32'h0001_0001;
    check_val("dl_txn_seen", 32'(ok), 1);
    check_val("dl_adr", 32'(t.adr), exp_adr);
    check_val("dl_sel", 32'(t.sel), exp_sel);
    check_val("dl_dat", t.dat, exp_dat);
    check_val("dl_we", 32'(t.we), 1);
    check_val("dl_wait_until_ack", 32'(t.wt), 1);
    @(negedge clk_sys);
    check_val("dl_wait_after_ack", 32'(dl_wait), 0);
  endtask

  initial begin
    txn_t t;
    bit   ok, acked;
    int   a0;
    logic [21:0] hold_adr;
    logic [31:0] hold_dat;

    // Reset values
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check_val("rst_ram_stb", 32'(ram_stb), 0);
    check_val("rst_ram_cyc", 32'(ram_cyc), 0);
    check_val("rst_dl_wait", 32'(dl_wait), 0);
    check_val("rst_dl_busy", 32'(dl_busy), 0);
    check_val("rst_ram_adr", 32'(ram_adr), 0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Ack with no strobe must not reach the core
    core_cyc = 1'b1;
    stray_ack = 1'b1;
    @(negedge clk_sys);
    check_val("stray_ack_core", 32'(core_ack), 0);
    stray_ack = 1'b0;
    core_cyc = 1'b0;
    repeat (2) @(negedge clk_sys);
    check_val("stray_ack_no_txn", 32'(txq.size()), 0);

    // Core read at 0x10 with a 3-cycle ack
    set_lat(3, 3);
    core_access(22'h000010, 1'b0, 4'hF, 32'h0);

    set_lat(1, 3);
    for (int i = 0; i < 8; i++) begin
      core_access(22'($urandom), 1'($urandom), 4'($urandom), $urandom);
    end

    // Full download: erase, halfword writes, end
    @(negedge clk_sys);
    dl_active = 1'b1;
    @(negedge clk_sys);
    check_val("dl_start_busy", 32'(dl_busy), 1);
    check_val("dl_start_wait", 32'(dl_wait), 1);
    expect_erase(EW);
    @(negedge clk_sys);
    check_val("erase_done_wait", 32'(dl_wait), 0);
    check_val("erase_done_stb", 32'(ram_stb), 0);
    check_val("erase_done_busy", 32'(dl_busy), 1);
    dl_write(22'h000002, 16'hA55A);
    for (int i = 0; i < 6; i++) begin
      dl_write(22'($urandom), 16'($urandom));
    end
    dl_active = 1'b0;
    @(negedge clk_sys);
    check_val("drain_busy", 32'(dl_busy), 1);
    check_val("drain_stb", 32'(ram_stb), 0);
    @(negedge clk_sys);
    check_val("end_busy", 32'(dl_busy), 0);
    core_access(22'($urandom), 1'b1, 4'hF, $urandom);

    // Download requested while a core write is outstanding
    set_lat(3, 3);
    hold_adr = 22'($urandom);
    hold_dat = $urandom;
    @(negedge clk_sys);
    a0 = core_ack_cnt;
    core_cyc = 1'b1; core_stb = 1'b1; core_we = 1'b1;
    core_sel = 4'hF; core_adr = hold_adr; core_dat_w = hold_dat;
    @(negedge clk_sys);
    dl_active = 1'b1;
    @(negedge clk_sys);
    check_val("pend_wait", 32'(dl_wait), 1);
    check_val("pend_hold_adr", 32'(ram_adr), 32'(hold_adr));
    acked = 1'b0;
    for (int i = 0; i < 50 && !acked; i++) begin
      @(negedge clk_sys);
      if (core_ack) acked = 1'b1;
    end
    check_val("pend_core_ack", 32'(acked), 1);
    wait_txn(t, ok);
    check_val("pend_core_adr", 32'(t.adr), 32'(hold_adr));
    check_val("pend_core_dat", t.dat, hold_dat);
    set_lat(1, 3);
    expect_erase(EW);
    @(negedge clk_sys);
    dl_active = 1'b0;
    acked = 1'b0;
    for (int i = 0; i < 50 && !acked; i++) begin
      @(negedge clk_sys);
      if (core_ack) acked = 1'b1;
    end
    check_val("held_core_served", 32'(acked), 1);
    check_val("held_core_busy", 32'(dl_busy), 0);
    @(posedge clk_sys);
    #2;
    core_cyc = 1'b0; core_stb = 1'b0; core_we = 1'b0;
    repeat (2) @(negedge clk_sys);
    #1;
    check_val("pend_core_acks", 32'(core_ack_cnt - a0), 2);
    wait_txn(t, ok);
    check_val("held_core_adr", 32'(t.adr), 32'(hold_adr));

    // Download aborted while erasing word 2
    @(negedge clk_sys);
    dl_active = 1'b1;
    wait_txn(t, ok);
    wait_txn(t, ok);
    check_val("abort_pre_adr", 32'(t.adr), 1);
    @(negedge clk_sys);
    dl_active = 1'b0;
    wait_txn(t, ok);
    check_val("abort_last_seen", 32'(ok), 1);
    check_val("abort_last_adr", 32'(t.adr), 2);
    @(negedge clk_sys);
    check_val("abort_drain_busy", 32'(dl_busy), 1);
    check_val("abort_drain_stb", 32'(ram_stb), 0);
    @(negedge clk_sys);
    check_val("abort_idle_busy", 32'(dl_busy), 0);
    repeat (3) @(negedge clk_sys);
    check_val("abort_no_more", 32'(txq.size()), 0);
    core_access(22'($urandom), 1'b0, 4'hF, 32'h0);

    // Reset during a download write, leaving reset with dl_active high
    @(negedge clk_sys);
    dl_active = 1'b1;
    expect_erase(EW);
    set_lat(3, 3);
    @(negedge clk_sys);
    dl_wr = 1'b1; dl_addr = 22'h00_1236; dl_data = 16'h1234;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    #1 check_val("rstw_in_write", 32'(ram_stb), 1);
    reset = 1'b1;
    @(negedge clk_sys);
    #1;
    check_val("rstw_stb", 32'(ram_stb), 0);
    check_val("rstw_cyc", 32'(ram_cyc), 0);
    check_val("rstw_we", 32'(ram_we), 0);
    check_val("rstw_sel", 32'(ram_sel), 0);
    check_val("rstw_adr", 32'(ram_adr), 0);
    check_val("rstw_dat", ram_dat_w, 0);
    check_val("rstw_wait", 32'(dl_wait), 0);
    check_val("rstw_busy", 32'(dl_busy), 0);
    check_val("rstw_core_ack", 32'(core_ack), 0);
    txq.delete();
    reset = 1'b0;
    set_lat(1, 3);
    @(negedge clk_sys);
    check_val("rst_rise_busy", 32'(dl_busy), 1);
    check_val("rst_rise_stb", 32'(ram_stb), 1);
    check_val("rst_rise_adr", 32'(ram_adr), 0);
    expect_erase(EW);
    dl_active = 1'b0;
    repeat (4) @(negedge clk_sys);
    check_val("final_busy", 32'(dl_busy), 0);

    check_val("no_ack_while_busy", 32'(busy_ack_viol), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
